// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity-mode encodings, counter width helper.
// Latency: n/a (package only).
// Backpressure: n/a. Shared with the transmitter so both sides agree on parity-mode encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Width of a counter that must hold 0..n-1 (never narrower than one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receiver-side bundle: line/tick/enable inputs, holding-register handshake, status flags.
// Latency: n/a (wiring only).
// Backpressure: rx_valid/rx_ready; master = receiver, slave = consumer/driver of the line.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_ena;
    logic                 rx_in;
    logic                 os_tick;
    logic                 rx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun_err;
    logic                 busy;

    modport master (
        input  rx_ena, rx_in, os_tick, rx_ready,
        output rx_data, rx_valid, frame_err, parity_err, overrun_err, busy
    );

    modport slave (
        output rx_ena, rx_in, os_tick, rx_ready,
        input  rx_data, rx_valid, frame_err, parity_err, overrun_err, busy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous rx line; resets to 1 (line idle).
// Latency: STAGES clk from i_async to o_sync.
// Backpressure: none. Ports: clk, rst (async, active-high), i_async, o_sync.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 3-sample majority per bit, optional parity, 1/2 stop bits.
// Latency: rx_valid 1 clk after the os_tick at the last stop-bit decision (+SYNC_STAGES on the line).
// Backpressure: single holding register; a frame completing while it is full and not read is dropped
// and flagged by a one-clk overrun_err. Ports: clk, rst (async, active-high), bus (master modport).
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = PAR_NONE,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_param_if.master bus
);

    localparam int OSW = cnt_w(OVERSAMPLE);
    localparam int BCW = cnt_w(DATA_BITS);
    localparam int M   = OVERSAMPLE / 2;

    localparam logic [OSW-1:0] C_OS_S0     = OSW'(M - 1);
    localparam logic [OSW-1:0] C_OS_S1     = OSW'(M);
    localparam logic [OSW-1:0] C_OS_DEC    = OSW'(M + 1);
    localparam logic [OSW-1:0] C_OS_LAST   = OSW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] C_DATA_LAST = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] C_STOP_LAST = BCW'(STOP_BITS - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [OSW-1:0]       r_os_cnt;
    logic [BCW-1:0]       r_bit_cnt;
    logic                 r_s0;
    logic                 r_s1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr_acc;
    logic                 r_ferr_acc;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_perr;
    logic                 r_ovr;

    logic w_rx;
    logic w_maj;
    logic w_decide;
    logic w_wrap;
    logic w_done;
    logic w_load;
    logic w_take;
    logic w_par_bad;

    uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.rx_in),
        .o_sync  (w_rx)
    );

    // Third sample is the live synchronised line at the decision tick.
    assign w_maj    = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
    assign w_decide = bus.os_tick && (r_os_cnt == C_OS_DEC);
    assign w_wrap   = bus.os_tick && (r_os_cnt == C_OS_LAST);

    // Even parity wants data^parity == 0, odd wants 1.
    assign w_par_bad = (PARITY_MODE == PAR_ODD) ? ~((^r_shift) ^ w_maj) : ((^r_shift) ^ w_maj);

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.os_tick && bus.rx_ena && !w_rx) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_decide && w_maj) begin
                    w_state_nxt = ST_IDLE;          // false start: glitch shorter than half a bit
                end else if (w_wrap) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_wrap && (r_bit_cnt == C_DATA_LAST)) begin
                    w_state_nxt = (PARITY_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (w_wrap) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // Finish mid-bit so a back-to-back start edge is not missed.
                if (w_decide && (r_bit_cnt == C_STOP_LAST)) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_os_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
            r_shift    <= '0;
            r_perr_acc <= 1'b0;
            r_ferr_acc <= 1'b0;
        end else if (bus.os_tick) begin
            if ((r_state == ST_IDLE) || (w_state_nxt == ST_IDLE)) begin
                r_os_cnt   <= '0;
                r_bit_cnt  <= '0;
                r_perr_acc <= 1'b0;
                r_ferr_acc <= 1'b0;
            end else begin
                r_os_cnt <= (r_os_cnt == C_OS_LAST) ? '0 : r_os_cnt + 1'b1;
                if (w_wrap) begin
                    r_bit_cnt <= (w_state_nxt != r_state) ? '0 : r_bit_cnt + 1'b1;
                end
                if (r_os_cnt == C_OS_S0) r_s0 <= w_rx;
                if (r_os_cnt == C_OS_S1) r_s1 <= w_rx;
                if (w_decide) begin
                    case (r_state)
                        ST_DATA:   r_shift    <= {w_maj, r_shift[DATA_BITS-1:1]};
                        ST_PARITY: r_perr_acc <= w_par_bad;
                        ST_STOP:   r_ferr_acc <= r_ferr_acc | ~w_maj;
                        default:   ;
                    endcase
                end
            end
        end
    end

    // Holding register: a same-clk read frees the slot for the completing frame.
    assign w_take = r_valid && bus.rx_ready;
    assign w_load = w_done && (!r_valid || bus.rx_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= w_done && r_valid && !bus.rx_ready;
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_ferr  <= r_ferr_acc | ~w_maj;
                r_perr  <= r_perr_acc;
            end else if (w_take) begin
                r_valid <= 1'b0;
                r_ferr  <= 1'b0;
                r_perr  <= 1'b0;
            end
        end
    end

    assign bus.rx_data     = r_data;
    assign bus.rx_valid    = r_valid;
    assign bus.frame_err   = r_ferr;
    assign bus.parity_err  = r_perr;
    assign bus.overrun_err = r_ovr;
    assign bus.busy        = (r_state != ST_IDLE);

endmodule
